// File: rtl/pe_fusion_acc_if.sv
// Beat/result bundle for pe_fusion_acc: packed operand bricks and control in,
// accumulated result handshake out.
interface pe_fusion_acc_if #(
    parameter int N_BRICK = 16,
    parameter int ACC_W   = 32
);
    logic [2*N_BRICK-1:0] i_activation;
    logic [2*N_BRICK-1:0] i_weight;
    logic                 i_A_signed;
    logic                 i_W_signed;
    logic [3:0]           i_shift_amount;
    logic                 i_valid;
    logic                 i_last;
    logic                 o_in_ready;
    logic                 o_valid;
    logic                 i_ready;
    logic [ACC_W-1:0]     o_acc;
    logic                 o_overflow;

    modport master (
        output i_activation, i_weight, i_A_signed, i_W_signed, i_shift_amount,
        output i_valid, i_last, i_ready,
        input  o_in_ready, o_valid, o_acc, o_overflow
    );

    modport slave (
        input  i_activation, i_weight, i_A_signed, i_W_signed, i_shift_amount,
        input  i_valid, i_last, i_ready,
        output o_in_ready, o_valid, o_acc, o_overflow
    );
endinterface

// File: rtl/pe_fusion_acc.sv
// Brick-serial fused multiply-accumulate PE: sums 2-bit brick products, shifts,
// and accumulates a group of beats with signed saturation, then holds the result.
module pe_fusion_acc #(
    parameter int N_BRICK = 16,
    parameter int ACC_W   = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    pe_fusion_acc_if.slave bus
);
    localparam int SUM_W = 5 + $clog2(N_BRICK);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    state_t state_reg, state_next;

    logic signed [4:0]       prod [N_BRICK];
    logic signed [SUM_W-1:0] brick_sum;
    logic [ACC_W-1:0]        shifted_sum;

    logic [ACC_W-1:0] s1_data_reg;
    logic             s1_valid_reg;
    logic             s1_last_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             overflow_reg;
    logic             out_valid_reg;

    logic             accept;
    logic             handshake;
    logic [ACC_W:0]   wide_sum;
    logic             sat_hi;
    logic             sat_lo;
    logic [ACC_W-1:0] sat_sum;

    // Each brick widened to 5 bits so the product (range -6..9) fits without loss.
    genvar gi;
    for (gi = 0; gi < N_BRICK; gi++) begin : g_brick
        logic [1:0]        a_bits;
        logic [1:0]        w_bits;
        logic signed [4:0] a_ext;
        logic signed [4:0] w_ext;
        assign a_bits   = bus.i_activation[2*gi +: 2];
        assign w_bits   = bus.i_weight[2*gi +: 2];
        assign a_ext    = {{3{bus.i_A_signed & a_bits[1]}}, a_bits};
        assign w_ext    = {{3{bus.i_W_signed & w_bits[1]}}, w_bits};
        assign prod[gi] = a_ext * w_ext;
    end

    always_comb begin
        brick_sum = '0;
        for (int k = 0; k < N_BRICK; k++) begin
            brick_sum = brick_sum + SUM_W'(prod[k]);
        end
    end

    assign shifted_sum = ACC_W'(brick_sum) << bus.i_shift_amount;

    assign accept    = bus.i_valid && (state_reg == ACCUM);
    assign handshake = out_valid_reg && bus.i_ready;

    // One extra bit exposes signed overflow as a mismatch of the top two bits.
    assign wide_sum = {acc_reg[ACC_W-1], acc_reg} + {s1_data_reg[ACC_W-1], s1_data_reg};
    assign sat_hi   = ~wide_sum[ACC_W] &  wide_sum[ACC_W-1];
    assign sat_lo   =  wide_sum[ACC_W] & ~wide_sum[ACC_W-1];
    assign sat_sum  = sat_hi ? ACC_MAX : (sat_lo ? ACC_MIN : wide_sum[ACC_W-1:0]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM:   if (accept && bus.i_last) state_next = DRAIN;
            DRAIN:   state_next = HOLD;
            HOLD:    if (handshake) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_data_reg   <= '0;
            s1_valid_reg  <= 1'b0;
            s1_last_reg   <= 1'b0;
            acc_reg       <= '0;
            overflow_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_data_reg <= shifted_sum;
                s1_last_reg <= bus.i_last;
            end
            if (handshake) begin
                acc_reg       <= '0;
                overflow_reg  <= 1'b0;
                out_valid_reg <= 1'b0;
            end else if (s1_valid_reg) begin
                acc_reg <= sat_sum;
                if (sat_hi || sat_lo) overflow_reg <= 1'b1;
                // The last beat of a group landing in the accumulator is what enters HOLD.
                if (s1_last_reg) out_valid_reg <= 1'b1;
            end
        end
    end

    assign bus.o_in_ready = (state_reg == ACCUM);
    assign bus.o_valid    = out_valid_reg;
    assign bus.o_acc      = acc_reg;
    assign bus.o_overflow = overflow_reg;
endmodule

// File: tb/tb_pe_fusion_acc.sv
// Directed-vector bench for pe_fusion_acc: a default-size instance and a
// narrow 4-brick/22-bit instance for the saturation cases.
module tb_pe_fusion_acc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pe_fusion_acc_if #(.N_BRICK(16), .ACC_W(32)) ifa ();
    pe_fusion_acc_if #(.N_BRICK(4),  .ACC_W(22)) ifb ();

    pe_fusion_acc #(.N_BRICK(16), .ACC_W(32)) dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa.slave));
    pe_fusion_acc #(.N_BRICK(4),  .ACC_W(22)) dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb.slave));

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat_a(input logic [31:0] act, input logic [31:0] wt, input logic as,
                          input logic ws, input logic [3:0] sh, input logic last);
        check("a_ready_at_beat", ifa.o_in_ready, 1);
        ifa.i_activation = act; ifa.i_weight = wt;
        ifa.i_A_signed = as; ifa.i_W_signed = ws;
        ifa.i_shift_amount = sh; ifa.i_last = last; ifa.i_valid = 1'b1;
        @(negedge clk);
        ifa.i_valid = 1'b0; ifa.i_last = 1'b0;
    endtask

    task automatic beat_b(input logic [7:0] act, input logic [7:0] wt, input logic as,
                          input logic ws, input logic [3:0] sh, input logic last);
        check("b_ready_at_beat", ifb.o_in_ready, 1);
        ifb.i_activation = act; ifb.i_weight = wt;
        ifb.i_A_signed = as; ifb.i_W_signed = ws;
        ifb.i_shift_amount = sh; ifb.i_last = last; ifb.i_valid = 1'b1;
        @(negedge clk);
        ifb.i_valid = 1'b0; ifb.i_last = 1'b0;
    endtask

    // Called one cycle after the last beat was accepted (t+1).
    task automatic result_a(input string tag, input logic signed [63:0] exp_acc, input logic exp_ovf);
        check({tag, "_t1_in_ready"}, ifa.o_in_ready, 0);
        check({tag, "_t1_valid"}, ifa.o_valid, 0);
        @(negedge clk);
        check({tag, "_t2_valid"}, ifa.o_valid, 1);
        check({tag, "_acc"}, $signed(ifa.o_acc), exp_acc);
        check({tag, "_ovf"}, ifa.o_overflow, exp_ovf);
        ifa.i_ready = 1'b1;
        @(negedge clk);
        ifa.i_ready = 1'b0;
        check({tag, "_post_in_ready"}, ifa.o_in_ready, 1);
        check({tag, "_post_valid"}, ifa.o_valid, 0);
        check({tag, "_post_acc"}, $signed(ifa.o_acc), 0);
    endtask

    task automatic result_b(input string tag, input logic signed [63:0] exp_acc, input logic exp_ovf);
        check({tag, "_t1_valid"}, ifb.o_valid, 0);
        @(negedge clk);
        check({tag, "_t2_valid"}, ifb.o_valid, 1);
        check({tag, "_acc"}, $signed(ifb.o_acc), exp_acc);
        check({tag, "_ovf"}, ifb.o_overflow, exp_ovf);
        ifb.i_ready = 1'b1;
        @(negedge clk);
        ifb.i_ready = 1'b0;
        check({tag, "_post_in_ready"}, ifb.o_in_ready, 1);
        check({tag, "_post_acc"}, $signed(ifb.o_acc), 0);
        check({tag, "_post_ovf"}, ifb.o_overflow, 0);
    endtask

    initial begin
        ifa.i_activation = '0; ifa.i_weight = '0; ifa.i_A_signed = 0; ifa.i_W_signed = 0;
        ifa.i_shift_amount = '0; ifa.i_valid = 0; ifa.i_last = 0; ifa.i_ready = 0;
        ifb.i_activation = '0; ifb.i_weight = '0; ifb.i_A_signed = 0; ifb.i_W_signed = 0;
        ifb.i_shift_amount = '0; ifb.i_valid = 0; ifb.i_last = 0; ifb.i_ready = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", ifa.o_in_ready, 1);
        check("rst_valid", ifa.o_valid, 0);
        check("rst_acc", $signed(ifa.o_acc), 0);
        check("rst_ovf", ifa.o_overflow, 0);
        check("rst_b_acc", $signed(ifb.o_acc), 0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned all-3 x all-3: 16 * 9 = 144
        beat_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 4'd0, 1);
        result_a("unsigned", 144, 0);

        // Signed -2 x unsigned 3 = -6 per brick, *16 = -96, <<2 = -384
        beat_a(32'hAAAA_AAAA, 32'hFFFF_FFFF, 1, 0, 4'd2, 1);
        result_a("signed_mixed", -384, 0);

        // Signed -2 x signed -2 = 4 per brick, *16 = 64
        beat_a(32'hAAAA_AAAA, 32'hAAAA_AAAA, 1, 1, 4'd0, 1);
        result_a("signed_both", 64, 0);

        // Signed 1 x unsigned 2 = 2 per brick, *16 = 32, <<3 = 256
        beat_a(32'h5555_5555, 32'hAAAA_AAAA, 1, 0, 4'd3, 1);
        result_a("pos_signed", 256, 0);

        // Single nonzero brick: unsigned 3 x signed -2 = -6
        beat_a(32'h0000_0003, 32'h0000_0002, 0, 1, 4'd0, 1);
        result_a("one_brick", -6, 0);

        // Back-to-back: 144 + 144<<4 + 144 = 2592
        beat_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 4'd0, 0);
        beat_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 4'd4, 0);
        beat_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 4'd0, 1);
        result_a("b2b", 2592, 0);

        // Idle cycles inside a group change nothing: 144 + 144 = 288
        beat_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 4'd0, 0);
        repeat (2) begin
            @(negedge clk);
            check("idle_in_ready", ifa.o_in_ready, 1);
            check("idle_valid", ifa.o_valid, 0);
        end
        beat_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 4'd0, 1);
        result_a("idle_gap", 288, 0);

        // Backpressure in HOLD with i_valid held high
        beat_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 4'd0, 1);
        @(negedge clk);
        ifa.i_valid = 1'b1; ifa.i_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", ifa.o_valid, 1);
            check("bp_acc", $signed(ifa.o_acc), 144);
            check("bp_ovf", ifa.o_overflow, 0);
            check("bp_in_ready", ifa.o_in_ready, 0);
        end
        ifa.i_ready = 1'b1;
        @(negedge clk);
        ifa.i_ready = 1'b0; ifa.i_valid = 1'b0; ifa.i_last = 1'b0;
        check("bp_release_in_ready", ifa.o_in_ready, 1);
        check("bp_release_valid", ifa.o_valid, 0);
        // Unsigned 1 x 1 per brick = 16; any absorbed HOLD beat would show here
        beat_a(32'h5555_5555, 32'h5555_5555, 0, 0, 4'd0, 1);
        result_a("bp_next", 16, 0);

        // Reset mid-group after two of three beats
        beat_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 4'd0, 0);
        beat_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 4'd0, 0);
        check("pre_rst_acc", $signed(ifa.o_acc), 144);
        rst = 1'b1;
        #1;
        check("midrst_acc", $signed(ifa.o_acc), 0);
        check("midrst_in_ready", ifa.o_in_ready, 1);
        check("midrst_valid", ifa.o_valid, 0);
        check("midrst_ovf", ifa.o_overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        beat_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 4'd0, 1);
        result_a("after_rst", 144, 0);

        // Positive saturation: 2 * (36 << 15) = 2359296 clips to 2097151
        beat_b(8'hFF, 8'hFF, 0, 0, 4'd15, 0);
        beat_b(8'hFF, 8'hFF, 0, 0, 4'd15, 1);
        result_b("sat_pos", 2097151, 1);
        beat_b(8'hFF, 8'hFF, 0, 0, 4'd0, 1);
        result_b("sat_clear", 36, 0);

        // Negative saturation: 3 * (-24 << 15) = -2359296 clips to -2097152
        beat_b(8'hAA, 8'hFF, 1, 0, 4'd15, 0);
        beat_b(8'hAA, 8'hFF, 1, 0, 4'd15, 0);
        beat_b(8'hAA, 8'hFF, 1, 0, 4'd15, 1);
        result_b("sat_neg", -2097152, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pe_fusion_acc.md
PE_FUSION_ACC -- requirements
Module: pe_fusion_acc

Interface
REQ-001 SHALL have parameter N_BRICK, default 16, giving the number of 2-bit bricks per operand (legal values 2..32).
REQ-002 SHALL have parameter ACC_W, default 32, giving the accumulator width (must satisfy ACC_W >= SUM_W+15, where SUM_W = 5+clog2(N_BRICK)).
REQ-003 SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_activation  input  2*N_BRICK  packed activation bricks; brick k = bits [2k+1:2k].
REQ-006 SHALL have port i_weight  input  2*N_BRICK  packed weight bricks, same layout.
REQ-007 SHALL have ports i_A_signed / i_W_signed  input  1 each  signedness of every activation / weight brick.
REQ-008 SHALL have port i_shift_amount  input  4  left shift applied to the brick sum (0..15).
REQ-009 SHALL have ports i_valid  input  1  input beat valid, and i_last  input  1  final beat of an accumulation group.
REQ-010 SHALL have port o_in_ready  output  1  input beat accepted when i_valid && o_in_ready.
REQ-011 SHALL have ports o_valid  output  1  result valid, and i_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port o_acc  output  ACC_W  signed accumulated result.
REQ-013 SHALL have port o_overflow  output  1  sticky saturation flag for the current group.

Function
REQ-014 SHALL compute each brick product from 2-bit slices: signed range -2..1 when the flag is 1, unsigned range 0..3 otherwise; result is a 5-bit signed product.
REQ-015 SHALL sum all N_BRICK products to SUM_W signed bits, sign-extend the sum to ACC_W, then shift it left by i_shift_amount.
REQ-016 SHALL register the shifted sum together with a valid bit and i_last into stage S1 in the cycle the beat is accepted.
REQ-017 SHALL add the S1 value to the accumulator one cycle after it enters S1, with signed saturation to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-018 SHALL set o_overflow on any saturating add; it then stays set until the result handshake.
REQ-019 SHALL implement FSM states ACCUM, DRAIN and HOLD, with o_in_ready = (state == ACCUM).
REQ-020 SHALL move ACCUM -> DRAIN on an accepted beat with i_last=1; otherwise it stays in ACCUM.
REQ-021 SHALL move DRAIN -> HOLD unconditionally after one cycle, during which the final S1 value is accumulated.
REQ-022 SHALL assert o_valid in HOLD only, with o_acc equal to the accumulator register (o_acc also reflects the accumulator in other states).
REQ-023 SHALL keep o_acc and o_overflow stable in HOLD while i_ready=0, and ignore i_valid there.
REQ-024 SHALL, on i_valid-independent handshake o_valid && i_ready, go HOLD -> ACCUM, clear the accumulator to 0 and clear o_overflow in the same edge.
REQ-025 SHALL give a latency from the accepted last beat (cycle t) to o_valid=1 of exactly 2 cycles (t+2).
REQ-026 SHALL accept back-to-back beats in ACCUM with no bubbles, one beat per cycle.
REQ-027 SHALL treat a single beat with i_last=1 as a complete group.
REQ-028 SHALL not change state on i_valid=0 cycles, and SHALL leave S1 valid=0 when no beat is accepted.

Reset
REQ-029 SHALL, on i_rst=1 at any time including mid-group, asynchronously clear the accumulator, S1 data and valid, o_overflow and o_valid to 0, and set state to ACCUM (o_in_ready=1).
REQ-030 SHALL start a fresh group from an accumulator of 0 on the first edge after i_rst deasserts.

Verification
REQ-031 Unsigned: all bricks a=11, w=11, both flags 0, shift 0, one beat with last=1 -> o_valid at t+2, o_acc=144, o_overflow=0.
REQ-032 Signed: a=10, w=11, A_signed=1, W_signed=0, shift 2, last=1 -> o_acc=-384; with a=10, w=10, both flags 1, shift 0 -> o_acc=64.
REQ-033 Accumulate: three back-to-back unsigned all-11 beats with shifts 0, 4, 0 (last on the third) -> o_acc=2592; o_in_ready=0 from t+1 until the handshake.
REQ-034 Saturation (N_BRICK=4, ACC_W=22): two all-11 unsigned beats, shift 15 -> o_acc=2097151, o_overflow=1; after the handshake the next single beat of 36 -> o_acc=36, o_overflow=0.
REQ-035 Backpressure: i_ready=0 for 5 cycles in HOLD with i_valid=1 -> o_valid, o_acc and o_overflow stable and no beat absorbed; i_ready=1 -> ACCUM, o_in_ready=1 the next cycle.
REQ-036 Reset mid-group: i_rst pulsed after 2 of 3 beats -> all outputs 0 and o_in_ready=1 immediately; a new single beat of 144 -> o_acc=144.
